// File: rtl/cic_comb_chain.sv
// Cascaded CIC comb sections (y = x - x[n-M]) for parallel lanes with lossless 1-bit growth per stage.
// Shared valid strobe and run-time differential delay; synchronous clear of all history.
module cic_comb_chain #(
  parameter  int WIDTH_IN   = 16,
  parameter  int NUM_STAGES = 3,
  parameter  int DELAY_MAX  = 2,
  parameter  int CHANNELS   = 2,
  localparam int WIDTH_OUT  = WIDTH_IN + NUM_STAGES,
  localparam int DSEL_W     = $clog2(DELAY_MAX + 1)
) (
  input  logic                            i_clock,
  input  logic                            i_reset_n,
  input  logic                            i_clear,
  input  logic [DSEL_W-1:0]               i_delay_sel,
  input  logic                            i_valid,
  input  logic [CHANNELS*WIDTH_IN-1:0]    i_data,
  output logic                            o_valid,
  output logic [CHANNELS*WIDTH_OUT-1:0]   o_data
);

  // History index of the x[n-M] tap; out-of-range selects fall back to the deepest tap.
  logic [DSEL_W-1:0] tap_idx;

  always_comb begin
    if (i_delay_sel == '0 || int'(i_delay_sel) > DELAY_MAX)
      tap_idx = DSEL_W'(DELAY_MAX - 1);
    else
      tap_idx = i_delay_sel - DSEL_W'(1);
  end

  genvar gs, gc;
  generate
    for (gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
      localparam int WS = WIDTH_IN + gs;
      localparam int WO = WS + 1;

      logic [CHANNELS*WS-1:0] x_flat;
      logic [CHANNELS*WO-1:0] y_flat;
      logic                   v_in;
      logic                   v_q;

      if (gs == 0) begin : g_first
        assign x_flat = i_data;
        assign v_in   = i_valid;
      end else begin : g_next
        assign x_flat = g_stage[gs-1].y_flat;
        assign v_in   = g_stage[gs-1].v_q;
      end

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
          v_q <= 1'b0;
        else if (i_clear)
          v_q <= 1'b0;
        else
          v_q <= v_in;
      end

      for (gc = 0; gc < CHANNELS; gc++) begin : g_chan
        logic signed [WS-1:0] x;
        logic signed [WS-1:0] tap;
        logic        [WS-1:0] hist [DELAY_MAX];
        logic signed [WO-1:0] y_q;

        assign x = x_flat[gc*WS +: WS];

        always_comb begin
          tap = '0;
          for (int k = 0; k < DELAY_MAX; k++)
            if (k == int'(tap_idx)) tap = hist[k];
        end

        // Operands widened by one sign bit so the difference can never wrap.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
          if (!i_reset_n) begin
            for (int k = 0; k < DELAY_MAX; k++) hist[k] <= '0;
            y_q <= '0;
          end else if (i_clear) begin
            for (int k = 0; k < DELAY_MAX; k++) hist[k] <= '0;
            y_q <= '0;
          end else if (v_in) begin
            hist[0] <= x;
            for (int k = 1; k < DELAY_MAX; k++) hist[k] <= hist[k-1];
            y_q <= {x[WS-1], x} - {tap[WS-1], tap};
          end
        end

        assign y_flat[gc*WO +: WO] = y_q;
      end
    end
  endgenerate

  assign o_data  = g_stage[NUM_STAGES-1].y_flat;
  assign o_valid = g_stage[NUM_STAGES-1].v_q;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain at default parameters (16-bit in, 3 stages, M up to 2, 2 lanes).
// Expected sequences below are worked out by hand from y = x - x[n-M] applied three times.
module tb_cic_comb_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [1:0]  sel;
  logic        vin;
  logic [31:0] din;
  logic        vout;
  logic [37:0] dout;

  logic signed [18:0] ch0;
  logic signed [18:0] ch1;
  assign ch0 = dout[18:0];
  assign ch1 = dout[37:19];

  always #5 clk = ~clk;

  cic_comb_chain dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_clear     (clr),
    .i_delay_sel (sel),
    .i_valid     (vin),
    .i_data      (din),
    .o_valid     (vout),
    .o_data      (dout)
  );

  int n_vec = 0;
  int n_err = 0;
  int in0 [32];
  int in1 [32];
  int ex0 [32];
  int ex1 [32];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic v, input int d0, input int d1);
    vin = v;
    din = {d1[15:0], d0[15:0]};
    @(posedge clk);
    #1;
  endtask

  task automatic zero_tables();
    for (int i = 0; i < 32; i++) begin
      in0[i] = 0; in1[i] = 0; ex0[i] = 0; ex1[i] = 0;
    end
  endtask

  // Clear is issued together with a valid sample that must be dropped.
  task automatic do_clear();
    clr = 1'b1;
    step(1'b1, 100, 100);
    clr = 1'b0;
    vin = 1'b0;
    chk("clear_valid", int'(vout), 0);
    chk("clear_ch0", int'(ch0), 0);
    chk("clear_ch1", int'(ch1), 0);
  endtask

  // Continuous valid stream of n samples; output of sample i lands after step i+2.
  task automatic run_seq(input string tag, input int n, input int sw_at,
                         input logic [1:0] sel_a, input logic [1:0] sel_b);
    for (int i = 0; i < n + 2; i++) begin
      sel = (i < sw_at) ? sel_a : sel_b;
      if (i < n) step(1'b1, in0[i], in1[i]);
      else       step(1'b0, 555, 555);
      if (i >= 2) begin
        chk({tag, "_valid"}, int'(vout), 1);
        chk({tag, "_ch0"}, int'(ch0), ex0[i-2]);
        chk({tag, "_ch1"}, int'(ch1), ex1[i-2]);
      end else begin
        chk({tag, "_lat"}, int'(vout), 0);
      end
    end
    vin = 1'b0;
  endtask

  initial begin
    int k_in, k_out, held;
    logic v;

    rst_n = 1'b0; clr = 1'b0; sel = 2'd1; vin = 1'b0; din = '0;
    #12;
    chk("reset_valid", int'(vout), 0);
    chk("reset_ch0", int'(ch0), 0);
    chk("reset_ch1", int'(ch1), 0);
    rst_n = 1'b1;

    // Impulse, M=1
    zero_tables();
    in0[0] = 1;
    ex0[0] = 1; ex0[1] = -3; ex0[2] = 3; ex0[3] = -1;
    run_seq("imp_m1", 8, 99, 2'd1, 2'd1);

    // Impulse, M=2, then selects 3 and 0 which clamp to M=2
    ex0[0] = 1; ex0[1] = 0; ex0[2] = -3; ex0[3] = 0;
    ex0[4] = 3; ex0[5] = 0; ex0[6] = -1; ex0[7] = 0;
    do_clear();
    run_seq("imp_m2", 8, 99, 2'd2, 2'd2);
    do_clear();
    run_seq("imp_sel3", 8, 99, 2'd3, 2'd3);
    do_clear();
    run_seq("imp_sel0", 8, 99, 2'd0, 2'd0);

    // Full-scale alternation, M=1: growth to +/-262140 without wrap
    zero_tables();
    for (int i = 0; i < 8; i++) in0[i] = (i % 2 == 0) ? 32767 : -32768;
    ex0[0] = 32767;   ex0[1] = -131069; ex0[2] = 229372; ex0[3] = -262140;
    ex0[4] = 262140;  ex0[5] = -262140; ex0[6] = 262140; ex0[7] = -262140;
    do_clear();
    run_seq("growth", 8, 99, 2'd1, 2'd1);

    // Impulse, M=1, with ~30% valid duty; o_data must hold between strobes
    zero_tables();
    in0[0] = 1;
    ex0[0] = 1; ex0[1] = -3; ex0[2] = 3; ex0[3] = -1;
    do_clear();
    sel = 2'd1;
    k_in = 0; k_out = 0; held = 0;
    for (int cyc = 0; cyc < 300 && k_out < 8; cyc++) begin
      v = (k_in < 8) && ($urandom_range(0, 9) < 3);
      step(v, v ? in0[k_in] : 777, v ? 0 : 777);
      if (v) k_in++;
      if (vout) begin
        chk("gap_ch0", int'(ch0), ex0[k_out]);
        chk("gap_ch1", int'(ch1), 0);
        held = ex0[k_out];
        k_out++;
      end else begin
        chk("gap_hold", int'(ch0), held);
      end
    end
    vin = 1'b0;
    chk("gap_count", k_out, 8);

    // DC 100 at M=2, clear with a simultaneous valid, then restart from zero history
    zero_tables();
    sel = 2'd2;
    for (int i = 0; i < 5; i++) step(1'b1, 100, 0);
    do_clear();
    for (int i = 0; i < 8; i++) in0[i] = 100;
    ex0[0] = 100; ex0[1] = 100; ex0[2] = -200; ex0[3] = -200;
    ex0[4] = 100; ex0[5] = 100;
    run_seq("dc_m2", 8, 99, 2'd2, 2'd2);
    do_clear();
    for (int i = 0; i < 8; i++) ex0[i] = 0;
    ex0[0] = 100; ex0[1] = -200; ex0[2] = 100;
    run_seq("dc_m1", 8, 99, 2'd1, 2'd1);

    // Asynchronous reset mid-stream
    do_clear();
    sel = 2'd1;
    for (int i = 0; i < 3; i++) step(1'b1, 100, 7);
    chk("pre_rst_ch0", int'(ch0), 100);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(vout), 0);
    chk("async_rst_ch0", int'(ch0), 0);
    chk("async_rst_ch1", int'(ch1), 0);
    vin = 1'b0;
    #2 rst_n = 1'b1;
    zero_tables();
    in0[0] = 1;
    ex0[0] = 1; ex0[1] = -3; ex0[2] = 3; ex0[3] = -1;
    run_seq("post_rst", 8, 99, 2'd1, 2'd1);

    // Ramp on ch1, M switches 1 -> 2 at sample 6 against the existing history
    zero_tables();
    for (int i = 0; i < 12; i++) in1[i] = i;
    ex1[0] = 0;  ex1[1] = 1;  ex1[2] = -1; ex1[3] = 0;
    ex1[4] = 0;  ex1[5] = 0;  ex1[6] = 1;  ex1[7] = 1;
    ex1[8] = -1; ex1[9] = -1; ex1[10] = 0; ex1[11] = 0;
    do_clear();
    run_seq("dswitch", 12, 6, 2'd1, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
